// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch control: one outstanding bus request, a one-entry skid buffer and redirect flushing.
// Optional INST_FETCH_ADEL_EN: misaligned PCs produce a local address-error response instead of a bus request.
module inst_fetch_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic              pc_adv,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [DATA_W-1:0] inst_rdata,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_adel,
  input  logic              id_allowin
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DROP,
    HOLD
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] req_pc;
  logic [ADDR_W-1:0] buf_pc;
  logic [DATA_W-1:0] buf_inst;
  logic              slot_free;
  logic              misaligned;
  logic              load_out;
  logic              load_buf;
  logic              from_buf;
  logic              req_accept;
  logic [ADDR_W-1:0] resp_pc;
  logic [DATA_W-1:0] resp_inst;

`ifdef INST_FETCH_ADEL_EN
  logic buf_adel;
  logic out_adel;
  logic resp_adel;
  assign misaligned = (pc[1:0] != 2'b00);
  assign if_adel    = out_adel;
`else
  assign misaligned = 1'b0;
  assign if_adel    = 1'b0;
`endif

  assign slot_free  = !if_valid || id_allowin;
  assign inst_addr  = (state == REQ) ? {pc[ADDR_W-1:2], 2'b00} : '0;
  assign req_accept = inst_req && inst_addr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A response (bus or synthesized) goes straight to the output slot when it is free,
  // otherwise into the buffer; flush overrides every load and every pc_adv.
  always_comb begin
    state_nxt = state;
    inst_req  = 1'b0;
    pc_adv    = 1'b0;
    load_out  = 1'b0;
    load_buf  = 1'b0;
    from_buf  = 1'b0;
    resp_pc   = req_pc;
    resp_inst = inst_rdata;
`ifdef INST_FETCH_ADEL_EN
    resp_adel = 1'b0;
`endif
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (!flush) begin
          if (misaligned) begin
            resp_pc   = pc;
            resp_inst = '0;
`ifdef INST_FETCH_ADEL_EN
            resp_adel = 1'b1;
`endif
            if (slot_free) begin
              load_out = 1'b1;
              pc_adv   = 1'b1;
            end else begin
              load_buf  = 1'b1;
              state_nxt = HOLD;
            end
          end else begin
            inst_req = 1'b1;
            if (inst_addr_ok) state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (flush) begin
          state_nxt = inst_data_ok ? REQ : DROP;
        end else if (inst_data_ok) begin
          if (slot_free) begin
            load_out  = 1'b1;
            pc_adv    = 1'b1;
            state_nxt = REQ;
          end else begin
            load_buf  = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      DROP: begin
        if (inst_data_ok) state_nxt = REQ;
      end
      HOLD: begin
        if (flush) begin
          state_nxt = REQ;
        end else if (id_allowin) begin
          from_buf  = 1'b1;
          load_out  = 1'b1;
          pc_adv    = 1'b1;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_pc   <= '0;
      buf_pc   <= '0;
      buf_inst <= '0;
`ifdef INST_FETCH_ADEL_EN
      buf_adel <= 1'b0;
`endif
    end else begin
      if (req_accept) req_pc <= pc;
      if (load_buf) begin
        buf_pc   <= resp_pc;
        buf_inst <= resp_inst;
`ifdef INST_FETCH_ADEL_EN
        buf_adel <= resp_adel;
`endif
      end
    end
  end

  // Output slot: flush clears it, a load refills it, otherwise it drains when decode accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_inst  <= '0;
`ifdef INST_FETCH_ADEL_EN
      out_adel <= 1'b0;
`endif
    end else if (flush) begin
      if_valid <= 1'b0;
    end else if (load_out) begin
      if_valid <= 1'b1;
      if_pc    <= from_buf ? buf_pc : resp_pc;
      if_inst  <= from_buf ? buf_inst : resp_inst;
`ifdef INST_FETCH_ADEL_EN
      out_adel <= from_buf ? buf_adel : resp_adel;
`endif
    end else if (id_allowin) begin
      if_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed testbench for inst_fetch_ctrl: reset, streaming, backpressure, flushes and the optional address-error path.
module tb_inst_fetch_ctrl;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] pc;
  logic              flush;
  logic              pc_adv;
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;
  logic              if_valid;
  logic [ADDR_W-1:0] if_pc;
  logic [DATA_W-1:0] if_inst;
  logic              if_adel;
  logic              id_allowin;

  int nerr = 0;
  int nchk = 0;

  inst_fetch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .flush(flush), .pc_adv(pc_adv),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .if_valid(if_valid),
    .if_pc(if_pc), .if_inst(if_inst), .if_adel(if_adel), .id_allowin(id_allowin)
  );

  always #5 clk = ~clk;

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic applyStimulus(input logic [31:0] p, input logic fl, input logic aok,
                               input logic dok, input logic [31:0] rd, input logic alw);
    @(negedge clk);
    pc           = p;
    flush        = fl;
    inst_addr_ok = aok;
    inst_data_ok = dok;
    inst_rdata   = rd;
    id_allowin   = alw;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    pc = '0; flush = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
    inst_rdata = '0; id_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pc = $urandom; flush = 1'($urandom); inst_addr_ok = 1'($urandom);
      inst_data_ok = 1'($urandom); inst_rdata = $urandom; id_allowin = 1'($urandom);
    end
    #1;
    checkOutput("rst_if_valid", if_valid, 0);
    checkOutput("rst_if_pc", if_pc, 0);
    checkOutput("rst_if_inst", if_inst, 0);
    checkOutput("rst_if_adel", if_adel, 0);
    checkOutput("rst_pc_adv", pc_adv, 0);
    checkOutput("rst_inst_req", inst_req, 0);
    checkOutput("rst_inst_addr", inst_addr, 0);

    // Release: still IDLE until the next rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    pc = 32'hBFC00000; flush = 0; inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = '0; id_allowin = 1;
    #1;
    checkOutput("rel_inst_req", inst_req, 0);

    // Zero-wait streaming.
    applyStimulus(32'hBFC00000, 0, 1, 0, 32'h0, 1);
    checkOutput("s1_inst_req", inst_req, 1);
    checkOutput("s1_inst_addr", inst_addr, 32'hBFC00000);
    checkOutput("s1_pc_adv", pc_adv, 0);
    applyStimulus(32'hBFC00000, 0, 0, 1, 32'h11111111, 1);
    checkOutput("s2_inst_req", inst_req, 0);
    checkOutput("s2_pc_adv", pc_adv, 1);
    applyStimulus(32'hBFC00004, 0, 1, 0, 32'h0, 1);
    checkOutput("s3_if_valid", if_valid, 1);
    checkOutput("s3_if_pc", if_pc, 32'hBFC00000);
    checkOutput("s3_if_inst", if_inst, 32'h11111111);
    checkOutput("s3_inst_addr", inst_addr, 32'hBFC00004);
    checkOutput("s3_pc_adv", pc_adv, 0);
    applyStimulus(32'hBFC00004, 0, 0, 1, 32'h22222222, 1);
    checkOutput("s4_if_valid", if_valid, 0);
    checkOutput("s4_pc_adv", pc_adv, 1);
    applyStimulus(32'hBFC00008, 0, 1, 0, 32'h0, 1);
    checkOutput("s5_if_pc", if_pc, 32'hBFC00004);
    checkOutput("s5_if_inst", if_inst, 32'h22222222);
    checkOutput("s5_inst_addr", inst_addr, 32'hBFC00008);
    applyStimulus(32'hBFC00008, 0, 0, 1, 32'h33333333, 1);
    checkOutput("s6_pc_adv", pc_adv, 1);
    applyStimulus(32'hBFC0000C, 0, 1, 0, 32'h0, 1);
    checkOutput("s7_if_pc", if_pc, 32'hBFC00008);
    checkOutput("s7_if_inst", if_inst, 32'h33333333);
    checkOutput("s7_inst_req", inst_req, 1);

    // Backpressure: first response to the output slot, second to the buffer.
    applyStimulus(32'hBFC0000C, 0, 0, 1, 32'h44444444, 0);
    checkOutput("bp1_pc_adv", pc_adv, 1);
    applyStimulus(32'hBFC00010, 0, 1, 0, 32'h0, 0);
    checkOutput("bp2_if_valid", if_valid, 1);
    checkOutput("bp2_if_pc", if_pc, 32'hBFC0000C);
    checkOutput("bp2_inst_req", inst_req, 1);
    applyStimulus(32'hBFC00010, 0, 0, 1, 32'h55555555, 0);
    checkOutput("bp3_pc_adv", pc_adv, 0);
    applyStimulus(32'hBFC00010, 0, 1, 0, 32'h0, 0);
    checkOutput("bp4_no_third_req", inst_req, 0);
    checkOutput("bp4_pc_adv", pc_adv, 0);
    checkOutput("bp4_if_inst", if_inst, 32'h44444444);
    applyStimulus(32'hBFC00010, 0, 0, 0, 32'h0, 1);
    checkOutput("bp5_pc_adv", pc_adv, 1);
    checkOutput("bp5_if_pc", if_pc, 32'hBFC0000C);
    applyStimulus(32'hBFC00014, 0, 0, 0, 32'h0, 1);
    checkOutput("bp6_if_valid", if_valid, 1);
    checkOutput("bp6_if_pc", if_pc, 32'hBFC00010);
    checkOutput("bp6_if_inst", if_inst, 32'h55555555);
    checkOutput("bp6_inst_req", inst_req, 1);
    checkOutput("bp6_pc_adv", pc_adv, 0);
    applyStimulus(32'hBFC00014, 0, 0, 0, 32'h0, 1);
    checkOutput("bp7_if_valid", if_valid, 0);

    // Flush while waiting; late response must be discarded.
    applyStimulus(32'hBFC00014, 0, 1, 0, 32'h0, 1);
    checkOutput("fw1_inst_req", inst_req, 1);
    applyStimulus(32'hBFC00014, 1, 0, 0, 32'h0, 1);
    checkOutput("fw2_pc_adv", pc_adv, 0);
    applyStimulus(32'h80000100, 0, 1, 0, 32'h0, 1);
    checkOutput("fw3_drop_no_req", inst_req, 0);
    applyStimulus(32'h80000100, 0, 1, 0, 32'h0, 1);
    applyStimulus(32'h80000100, 0, 0, 1, 32'hDEADBEEF, 1);
    checkOutput("fw4_pc_adv", pc_adv, 0);
    applyStimulus(32'h80000100, 0, 1, 0, 32'h0, 1);
    checkOutput("fw5_if_valid", if_valid, 0);
    checkOutput("fw5_inst_req", inst_req, 1);
    checkOutput("fw5_inst_addr", inst_addr, 32'h80000100);
    applyStimulus(32'h80000100, 0, 0, 1, 32'hAAAA0001, 1);
    checkOutput("fw6_pc_adv", pc_adv, 1);
    applyStimulus(32'h80000104, 0, 1, 0, 32'h0, 0);
    checkOutput("fw7_if_pc", if_pc, 32'h80000100);
    checkOutput("fw7_if_inst", if_inst, 32'hAAAA0001);

    // Flush coincident with data_ok and a still-valid output slot.
    applyStimulus(32'h80000104, 1, 0, 1, 32'hBADBAD00, 1);
    checkOutput("fd1_pc_adv", pc_adv, 0);
    checkOutput("fd1_if_valid_pre", if_valid, 1);
    applyStimulus(32'h90000000, 0, 0, 0, 32'h0, 1);
    checkOutput("fd2_if_valid", if_valid, 0);
    checkOutput("fd2_inst_req", inst_req, 1);
    checkOutput("fd2_inst_addr", inst_addr, 32'h90000000);

    // Flush in REQ gates the request.
    applyStimulus(32'h90000000, 1, 1, 0, 32'h0, 1);
    checkOutput("fr1_inst_req", inst_req, 0);
    applyStimulus(32'h90000040, 0, 0, 0, 32'h0, 1);
    checkOutput("fr2_inst_req", inst_req, 1);
    checkOutput("fr2_inst_addr", inst_addr, 32'h90000040);

    // Misaligned PC.
`ifdef INST_FETCH_ADEL_EN
    applyStimulus(32'hBFC00002, 0, 0, 0, 32'h0, 1);
    checkOutput("ad1_inst_req", inst_req, 0);
    checkOutput("ad1_pc_adv", pc_adv, 1);
    applyStimulus(32'hBFC00008, 0, 0, 0, 32'h0, 1);
    checkOutput("ad2_if_valid", if_valid, 1);
    checkOutput("ad2_if_adel", if_adel, 1);
    checkOutput("ad2_if_inst", if_inst, 0);
    checkOutput("ad2_if_pc", if_pc, 32'hBFC00002);
`else
    applyStimulus(32'hBFC00002, 0, 0, 0, 32'h0, 1);
    checkOutput("ad1_inst_req", inst_req, 1);
    checkOutput("ad1_inst_addr", inst_addr, 32'hBFC00000);
    checkOutput("ad1_pc_adv", pc_adv, 0);
    applyStimulus(32'hBFC00002, 0, 0, 0, 32'h0, 1);
    checkOutput("ad2_if_valid", if_valid, 0);
    checkOutput("ad2_if_adel", if_adel, 0);
`endif

    // Reset mid-transaction returns to the reset state immediately.
    applyStimulus(32'hBFC00008, 0, 1, 0, 32'h0, 1);
    applyStimulus(32'hBFC00008, 0, 0, 1, 32'h12345678, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("mr_pc_adv", pc_adv, 0);
    checkOutput("mr_inst_req", inst_req, 0);
    checkOutput("mr_if_valid", if_valid, 0);
    applyStimulus(32'hBFC00008, 0, 0, 0, 32'h0, 1);
    checkOutput("mr_if_pc", if_pc, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
